multichannel_sample_history: RTL
================================

Name: multichannel_sample_history

Overview:
- Parametrised per-channel sample history buffer. It replaces the fixed 14-channel, 8-bit, 10-deep shift buffer.
- Each channel keeps a circular history of its last DEPTH samples, plus a fill count and a running sum of the stored samples.
- A random-access read port returns one stored sample and that channel's statistics.
- Sits between the input sampling front end and the display/output formatter in the top-level wrapper.

Parameters:
- NUM_CHANNELS, 14, number of independent channels (1..64).
- SAMPLE_WIDTH, 8, bits per sample (1..16).
- DEPTH, 10, samples retained per channel (2..32, need not be a power of two).

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- wr_valid, input, 1, write strobe for one sample.
- wr_channel, input, CH_W=clog2(NUM_CHANNELS), target channel of the write.
- wr_data, input, SAMPLE_WIDTH, sample value.
- clr_valid, input, 1, clear one channel.
- clr_channel, input, CH_W, channel to clear.
- rd_valid, input, 1, read request.
- rd_channel, input, CH_W, channel to read.
- rd_index, input, IDX_W=clog2(DEPTH), age of the sample: 0 = newest.
- rsp_valid, output, 1, read response strobe, one cycle after rd_valid.
- rsp_data, output, SAMPLE_WIDTH, requested sample.
- rsp_hit, output, 1, 1 when rd_index < fill count of the channel.
- rsp_count, output, CNT_W=clog2(DEPTH+1), fill count of the channel.
- rsp_sum, output, SUM_W=SAMPLE_WIDTH+CNT_W, running sum of the channel.
- err_channel, output, 1, sticky error flag for out-of-range channel numbers.

Behaviour:
- Reset:
  - Every channel's write pointer and count go to 0, and every sum goes to 0.
  - rsp_valid, rsp_data, rsp_hit, rsp_count, rsp_sum and err_channel go to 0.
  - Sample storage contents are not reset. They must never be visible, because rsp_hit gates rsp_data.
- Write (wr_valid=1, channel in range):
  - Store wr_data at wr_ptr[ch].
  - wr_ptr increments and wraps from DEPTH-1 to 0.
  - If count < DEPTH: count += 1 and sum += wr_data.
  - If count == DEPTH: the oldest sample (the slot being overwritten) is evicted, so sum = sum - evicted + wr_data and count stays at DEPTH.
  - All updates take effect on the clock edge. Writes always complete; there is no backpressure.
- Clear (clr_valid=1, channel in range):
  - count, wr_ptr and sum of that channel go to 0 on the edge.
  - Clear beats a write to the same channel in the same cycle; that write is dropped.
  - A clear and a write to different channels both take effect.
- Read (rd_valid=1):
  - Latency is exactly 1 cycle: rsp_* are registered and rsp_valid pulses for one cycle.
  - Physical slot = (wr_ptr - 1 - rd_index) mod DEPTH.
  - If rd_index >= count: rsp_hit=0 and rsp_data=0. rsp_count and rsp_sum are still valid.
  - A read in the same cycle as a write or clear to the same channel returns the pre-update state (read-before-write).
  - When rd_valid=0 in a cycle, rsp_valid=0 next cycle and the other rsp_* outputs hold their values.
- Out-of-range channels:
  - Any wr, clr or rd strobe with channel >= NUM_CHANNELS is ignored.
  - It sets err_channel, which stays set until reset.
  - An ignored read still produces rsp_valid with rsp_hit=0, rsp_data=0, rsp_count=0 and rsp_sum=0.
- Arithmetic:
  - The sum never overflows by construction: SUM_W covers DEPTH*(2^SAMPLE_WIDTH-1).
  - Pointer wrap uses a compare-and-reset, not modulo, so that non-power-of-two DEPTH works.
- Channels are fully independent. Per-channel state is a pointer, a count and a sum, each held in registers.

Decomposition:
- Package msh_pkg holds:
  - the CH_W, IDX_W, CNT_W and SUM_W width functions;
  - a wrap-increment function;
  - the slot-index function (wr_ptr, rd_index, DEPTH).
- Sub-module msh_channel holds one channel: its DEPTH x SAMPLE_WIDTH storage, pointer, count, sum and slot read mux.
  - The top level instantiates NUM_CHANNELS copies with a generate loop.
  - The top level also holds the channel decode, the response mux/register and err_channel.

Test Plan:
- Fill after reset: write ch3 with samples 1..10, then read ch3 at index 0 and index 9 -> rsp_data=10 then 1, rsp_count=10, rsp_sum=55, rsp_hit=1.
- Wrap and evict: continue writing ch3 with 11 and 12 -> read index 0 gives 12, index 9 gives 3, count=10, sum=75. Read ch2 -> count=0, sum=0, hit=0.
- Partial fill: write ch0 with 200 and 100, then read index 2 -> rsp_hit=0, rsp_data=0, rsp_count=2, rsp_sum=300.
- Simultaneous events:
  - Same cycle: write 7 to ch5 and read ch5 index 0, with ch5 holding only a single sample 4 -> response gives 4 (pre-write). Next read gives 7.
  - Same cycle: write to ch5 and clear ch5 -> count=0.
- Error path: wr_valid with wr_channel=14 (NUM_CHANNELS=14) -> no channel state changes and err_channel=1. It persists until reset, after which err_channel=0.
- Parameter sweep and reset mid-run: repeat the first four scenarios with (NUM_CHANNELS=3, SAMPLE_WIDTH=12, DEPTH=5), using writes of 4095 to check sum=20475. Then assert reset mid-stream -> all counts and sums read 0.

Source files
------------

// File: rtl/msh_pkg.sv
// Shared widths and pointer helpers for the multichannel sample history.
// Pointer arithmetic avoids modulo so any history depth works.
package msh_pkg;

  // Channel number width; a single channel still gets one bit.
  function automatic int ch_w(input int num_channels);
    return (num_channels <= 1) ? 1 : $clog2(num_channels);
  endfunction

  // Width of a slot pointer or a read age.
  function automatic int idx_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Width of a fill count, which must be able to hold DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Running sum width; DEPTH full-scale samples always fit.
  function automatic int sum_w(input int sample_width, input int depth);
    return sample_width + cnt_w(depth);
  endfunction

  // Advance a circular pointer, wrapping from depth-1 back to 0.
  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

  // Physical slot holding the sample of age rd_index (0 = newest).
  // Ages at or beyond depth are never hits, so they just map to slot 0.
  function automatic int slot_index(input int wr_ptr, input int rd_index, input int depth);
    int slot;
    if (rd_index >= depth) begin
      return 0;
    end
    slot = wr_ptr - 1 - rd_index;
    if (slot < 0) begin
      slot = slot + depth;
    end
    return slot;
  endfunction

endpackage

// File: rtl/multichannel_sample_history_if.sv
// Write / clear / read request bundle and registered read response
// for the multichannel sample history.
interface multichannel_sample_history_if #(
  parameter int NUM_CHANNELS = 14,
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 10
);

  localparam int CH_W  = msh_pkg::ch_w(NUM_CHANNELS);
  localparam int IDX_W = msh_pkg::idx_w(DEPTH);
  localparam int CNT_W = msh_pkg::cnt_w(DEPTH);
  localparam int SUM_W = msh_pkg::sum_w(SAMPLE_WIDTH, DEPTH);

  logic                    wr_valid;
  logic [CH_W-1:0]         wr_channel;
  logic [SAMPLE_WIDTH-1:0] wr_data;

  logic                    clr_valid;
  logic [CH_W-1:0]         clr_channel;

  logic                    rd_valid;
  logic [CH_W-1:0]         rd_channel;
  logic [IDX_W-1:0]        rd_index;

  logic                    rsp_valid;
  logic [SAMPLE_WIDTH-1:0] rsp_data;
  logic                    rsp_hit;
  logic [CNT_W-1:0]        rsp_count;
  logic [SUM_W-1:0]        rsp_sum;
  logic                    err_channel;

  // Requester side: front end / formatter.
  modport master (
    output wr_valid, wr_channel, wr_data,
    output clr_valid, clr_channel,
    output rd_valid, rd_channel, rd_index,
    input  rsp_valid, rsp_data, rsp_hit, rsp_count, rsp_sum, err_channel
  );

  // History buffer side.
  modport slave (
    input  wr_valid, wr_channel, wr_data,
    input  clr_valid, clr_channel,
    input  rd_valid, rd_channel, rd_index,
    output rsp_valid, rsp_data, rsp_hit, rsp_count, rsp_sum, err_channel
  );

endinterface

// File: rtl/msh_channel.sv
// One channel of sample history: circular storage, write pointer,
// fill count, running sum and a combinational read of one slot.
module msh_channel
  import msh_pkg::*;
#(
  parameter int  SAMPLE_WIDTH = 8,
  parameter int  DEPTH        = 10,
  localparam int IDX_W        = idx_w(DEPTH),
  localparam int CNT_W        = cnt_w(DEPTH),
  localparam int SUM_W        = sum_w(SAMPLE_WIDTH, DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [SAMPLE_WIDTH-1:0] wr_data,
  input  logic                    clr_en,
  input  logic [IDX_W-1:0]        rd_index,
  output logic [SAMPLE_WIDTH-1:0] rd_data,
  output logic                    rd_hit,
  output logic [CNT_W-1:0]        count,
  output logic [SUM_W-1:0]        sum
);

  logic [SAMPLE_WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        fill;
  logic [SUM_W-1:0]        total;
  logic                    full;
  logic                    accept;
  logic [SAMPLE_WIDTH-1:0] evicted;
  logic [IDX_W-1:0]        rd_slot;

  // A clear always wins over a write landing on the same edge.
  assign accept  = wr_en && !clr_en;
  assign full    = (fill == CNT_W'(DEPTH));
  assign evicted = mem[wr_ptr];
  assign count   = fill;
  assign sum     = total;

  // Sample storage is deliberately not reset; rd_hit hides stale slots.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer, fill count and running sum; once full, the overwritten slot leaves the sum.
  always_ff @(posedge clk) begin
    if (reset || clr_en) begin
      wr_ptr <= '0;
      fill   <= '0;
      total  <= '0;
    end else if (accept) begin
      wr_ptr <= IDX_W'(wrap_inc(int'(wr_ptr), DEPTH));
      if (full) begin
        total <= total - SUM_W'(evicted) + SUM_W'(wr_data);
      end else begin
        fill  <= fill + 1'b1;
        total <= total + SUM_W'(wr_data);
      end
    end
  end

  // Age-to-slot lookup; anything older than the fill count reads as zero.
  always_comb begin
    rd_slot = IDX_W'(slot_index(int'(wr_ptr), int'(rd_index), DEPTH));
    rd_hit  = (CNT_W'(rd_index) < fill);
    rd_data = '0;
    if (rd_hit) begin
      rd_data = mem[rd_slot];
    end
  end

endmodule

// File: rtl/multichannel_sample_history.sv
// Multichannel sample history: decodes writes/clears to independent
// channels, registers a one-cycle read response and flags bad channel numbers.
module multichannel_sample_history
  import msh_pkg::*;
#(
  parameter int NUM_CHANNELS = 14,
  parameter int SAMPLE_WIDTH = 8,
  parameter int DEPTH        = 10
) (
  input logic                          clk,
  input logic                          reset,
  multichannel_sample_history_if.slave bus
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam int SUM_W = sum_w(SAMPLE_WIDTH, DEPTH);

  logic                    wr_in_range;
  logic                    clr_in_range;
  logic                    rd_in_range;
  logic                    bad_strobe;

  logic [NUM_CHANNELS-1:0] wr_en;
  logic [NUM_CHANNELS-1:0] clr_en;

  logic [SAMPLE_WIDTH-1:0] ch_data  [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] ch_hit;
  logic [CNT_W-1:0]        ch_count [NUM_CHANNELS];
  logic [SUM_W-1:0]        ch_sum   [NUM_CHANNELS];

  logic [SAMPLE_WIDTH-1:0] sel_data;
  logic                    sel_hit;
  logic [CNT_W-1:0]        sel_count;
  logic [SUM_W-1:0]        sel_sum;

  logic                    rsp_valid_q;
  logic [SAMPLE_WIDTH-1:0] rsp_data_q;
  logic                    rsp_hit_q;
  logic [CNT_W-1:0]        rsp_count_q;
  logic [SUM_W-1:0]        rsp_sum_q;
  logic                    err_q;

  assign wr_in_range  = (int'(bus.wr_channel)  < NUM_CHANNELS);
  assign clr_in_range = (int'(bus.clr_channel) < NUM_CHANNELS);
  assign rd_in_range  = (int'(bus.rd_channel)  < NUM_CHANNELS);

  assign bad_strobe = (bus.wr_valid  && !wr_in_range)  ||
                      (bus.clr_valid && !clr_in_range) ||
                      (bus.rd_valid  && !rd_in_range);

  // Channel decode; a clear suppresses a same-cycle write to that channel.
  always_comb begin
    wr_en  = '0;
    clr_en = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      clr_en[i] = bus.clr_valid && clr_in_range && (int'(bus.clr_channel) == i);
      wr_en[i]  = bus.wr_valid && wr_in_range && (int'(bus.wr_channel) == i) && !clr_en[i];
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
    msh_channel #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .DEPTH        (DEPTH)
    ) u_channel (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (wr_en[g]),
      .wr_data  (bus.wr_data),
      .clr_en   (clr_en[g]),
      .rd_index (bus.rd_index),
      .rd_data  (ch_data[g]),
      .rd_hit   (ch_hit[g]),
      .count    (ch_count[g]),
      .sum      (ch_sum[g])
    );
  end

  // Read mux; an out-of-range channel reads as an empty channel.
  always_comb begin
    sel_data  = '0;
    sel_hit   = 1'b0;
    sel_count = '0;
    sel_sum   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if (rd_in_range && (int'(bus.rd_channel) == i)) begin
        sel_data  = ch_data[i];
        sel_hit   = ch_hit[i];
        sel_count = ch_count[i];
        sel_sum   = ch_sum[i];
      end
    end
  end

  // Response register: captures pre-update channel state, holds when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_count_q <= '0;
      rsp_sum_q   <= '0;
    end else begin
      rsp_valid_q <= bus.rd_valid;
      if (bus.rd_valid) begin
        rsp_data_q  <= sel_data;
        rsp_hit_q   <= sel_hit;
        rsp_count_q <= sel_count;
        rsp_sum_q   <= sel_sum;
      end
    end
  end

  // Sticky error for any strobe naming a channel that does not exist.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (bad_strobe) begin
      err_q <= 1'b1;
    end
  end

  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_hit     = rsp_hit_q;
  assign bus.rsp_count   = rsp_count_q;
  assign bus.rsp_sum     = rsp_sum_q;
  assign bus.err_channel = err_q;

endmodule
